// File: rtl/mem_stage_ctrl.sv
// MEM-stage data-memory controller: fixed-latency RAM access, upstream stall and MEM/WB output registers.
// Optional stall-cycle counter on stall_cnt_o when DMEM_STALL_CNT_EN is defined.
module mem_stage_ctrl #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned LAT    = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              memRead_i,
   input  logic              memWrite_i,
   input  logic [ADDR_W-1:0] memAddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [DATA_W-1:0] alu_i,
   input  logic              overflow_i,
   input  logic [2:0]        data_rd_i,
   input  logic              regWrite_i,
   output logic              stall_o,
   output logic [DATA_W-1:0] wb_data_o,
   output logic              overflow_o,
   output logic [2:0]        data_rd_o,
   output logic              regWrite_o
`ifdef DMEM_STALL_CNT_EN
   ,
   output logic [15:0]       stall_cnt_o
`endif
);

   localparam int unsigned CNT_W = 4;
   localparam int unsigned DEPTH = 2 ** ADDR_W;

   typedef enum logic [0:0] {IDLE, BUSY} state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] mem [DEPTH];

   logic req;
   logic last_cyc;
   logic mem_we;
   logic load_sel;

   assign req      = memRead_i | memWrite_i;
   assign last_cyc = (state == BUSY) && (cnt == '0);
   assign mem_we   = last_cyc && memWrite_i;
   // A simultaneous read+write request is treated as a store.
   assign load_sel = last_cyc && memRead_i && !memWrite_i;

   assign stall_o = ((state == IDLE) && req) || ((state == BUSY) && (cnt != '0));

   // RAM is never reset; a store only lands on its completing edge.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[memAddr_i] <= wdata_i;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         wb_data_o  <= '0;
         overflow_o <= 1'b0;
         data_rd_o  <= '0;
         regWrite_o <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  state      <= BUSY;
                  cnt        <= CNT_W'(LAT - 1);
                  wb_data_o  <= '0;
                  overflow_o <= 1'b0;
                  data_rd_o  <= '0;
                  regWrite_o <= 1'b0;
               end else begin
                  wb_data_o  <= alu_i;
                  overflow_o <= overflow_i;
                  data_rd_o  <= data_rd_i;
                  regWrite_o <= regWrite_i;
               end
            end
            BUSY: begin
               if (cnt != '0) begin
                  cnt        <= cnt - CNT_W'(1);
                  wb_data_o  <= '0;
                  overflow_o <= 1'b0;
                  data_rd_o  <= '0;
                  regWrite_o <= 1'b0;
               end else begin
                  state      <= IDLE;
                  wb_data_o  <= load_sel ? mem[memAddr_i] : alu_i;
                  overflow_o <= overflow_i;
                  data_rd_o  <= data_rd_i;
                  regWrite_o <= regWrite_i;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

`ifdef DMEM_STALL_CNT_EN
   logic [15:0] stall_cnt_q;

   // Saturating count of stalled cycles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_q <= '0;
      end else if (stall_o && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: directed ops push expected writeback, a monitor pops and compares.
module tb_mem_stage_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       memRead_i, memWrite_i;
   logic [7:0] memAddr_i, wdata_i, alu_i;
   logic       overflow_i;
   logic [2:0] data_rd_i;
   logic       regWrite_i;
   logic       stall_o;
   logic [7:0] wb_data_o;
   logic       overflow_o;
   logic [2:0] data_rd_o;
   logic       regWrite_o;
`ifdef DMEM_STALL_CNT_EN
   logic [15:0] stall_cnt_o;
`endif

   typedef struct packed {
      logic [7:0] wb;
      logic       ovf;
      logic [2:0] rd;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   mem_stage_ctrl #(.DATA_W(8), .ADDR_W(8), .LAT(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .memRead_i  (memRead_i),
      .memWrite_i (memWrite_i),
      .memAddr_i  (memAddr_i),
      .wdata_i    (wdata_i),
      .alu_i      (alu_i),
      .overflow_i (overflow_i),
      .data_rd_i  (data_rd_i),
      .regWrite_i (regWrite_i),
      .stall_o    (stall_o),
      .wb_data_o  (wb_data_o),
      .overflow_o (overflow_o),
      .data_rd_o  (data_rd_o),
      .regWrite_o (regWrite_o)
`ifdef DMEM_STALL_CNT_EN
      ,
      .stall_cnt_o(stall_cnt_o)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic drive_idle();
      memRead_i  = 1'b0;
      memWrite_i = 1'b0;
      memAddr_i  = 8'h00;
      wdata_i    = 8'h00;
      alu_i      = 8'h00;
      overflow_i = 1'b0;
      data_rd_i  = 3'd0;
      regWrite_i = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         drive_idle();
      end
   endtask

   // Issue one op, hold it through the stall, check bubbles and stall length.
   task automatic op(input logic rd_en, input logic wr_en, input logic [7:0] addr,
                     input logic [7:0] wdata, input logic [7:0] alu, input logic ovf,
                     input logic [2:0] rd, input logic [7:0] exp_wb, input int exp_stalls,
                     input string name);
      int n;
      @(negedge clk);
      memRead_i  = rd_en;
      memWrite_i = wr_en;
      memAddr_i  = addr;
      wdata_i    = wdata;
      alu_i      = alu;
      overflow_i = ovf;
      data_rd_i  = rd;
      regWrite_i = 1'b1;
      exp_q.push_back('{wb: exp_wb, ovf: ovf, rd: rd});
      #1;
      n = 0;
      while (stall_o && n < 50) begin
         n++;
         @(negedge clk);
         #1;
         chk({name, "_bubble"}, 32'(regWrite_o), 32'd0);
      end
      chk({name, "_stalls"}, 32'(n), 32'(exp_stalls));
   endtask

   // Monitor: every presented writeback must match the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (regWrite_o === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_wb actual=%0h expected=none", wb_data_o);
            end else begin
               e = exp_q.pop_front();
               if ({wb_data_o, overflow_o, data_rd_o} !== e) begin
                  failures++;
                  $display("FAIL wb actual=wb:%0h ovf:%0b rd:%0d expected=wb:%0h ovf:%0b rd:%0d",
                           wb_data_o, overflow_o, data_rd_o, e.wb, e.ovf, e.rd);
               end
            end
         end
      end
   end

   initial begin
      drive_idle();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_wb", 32'(wb_data_o), 32'h0);
      chk("rst_regwrite", 32'(regWrite_o), 32'h0);
      chk("rst_rd", 32'(data_rd_o), 32'h0);
      chk("rst_ovf", 32'(overflow_o), 32'h0);
      chk("rst_stall", 32'(stall_o), 32'h0);
      @(negedge clk);
      reset = 1'b0;

      // Three back-to-back stores, each stalling LAT=2 cycles.
      op(1'b0, 1'b1, 8'h3C, 8'hA5, 8'h40, 1'b0, 3'd1, 8'h40, 2, "st_3c");
      op(1'b0, 1'b1, 8'h3D, 8'h66, 8'h41, 1'b0, 3'd2, 8'h41, 2, "st_3d");
      op(1'b0, 1'b1, 8'h3E, 8'h77, 8'h42, 1'b1, 3'd3, 8'h42, 2, "st_3e");
      idle(1);
`ifdef DMEM_STALL_CNT_EN
      #1;
      chk("stall_cnt_6", 32'(stall_cnt_o), 32'd6);
      @(negedge clk);
      force dut.stall_cnt_q = 16'hFFFE;
      #1;
      release dut.stall_cnt_q;
      op(1'b0, 1'b1, 8'h3F, 8'h88, 8'h43, 1'b0, 3'd4, 8'h43, 2, "st_3f");
      idle(1);
      #1;
      chk("stall_cnt_sat", 32'(stall_cnt_o), 32'hFFFF);
`endif

      op(1'b0, 1'b0, 8'h00, 8'h00, 8'h7F, 1'b1, 3'd3, 8'h7F, 0, "alu_7f");
      op(1'b1, 1'b0, 8'h3C, 8'h00, 8'h99, 1'b0, 3'd5, 8'hA5, 2, "ld_3c");
      // Load followed immediately by an ALU op: no extra stall.
      op(1'b1, 1'b0, 8'h3C, 8'h00, 8'h00, 1'b0, 3'd2, 8'hA5, 2, "ld_3c_b2b");
      op(1'b0, 1'b0, 8'h00, 8'h00, 8'h11, 1'b0, 3'd4, 8'h11, 0, "alu_11");
      op(1'b1, 1'b0, 8'h3D, 8'h00, 8'h00, 1'b1, 3'd6, 8'h66, 2, "ld_3d");
      op(1'b1, 1'b0, 8'h3E, 8'h00, 8'h00, 1'b0, 3'd7, 8'h77, 2, "ld_3e");
      // Read+write together acts as a store returning the ALU result.
      op(1'b1, 1'b1, 8'h00, 8'h5A, 8'h22, 1'b0, 3'd7, 8'h22, 2, "rw_both");
      op(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 3'd1, 8'h5A, 2, "ld_00");
      // Overwrite then read back.
      op(1'b0, 1'b1, 8'h3C, 8'hC3, 8'h01, 1'b0, 3'd0, 8'h01, 2, "st_3c_c3");
      op(1'b1, 1'b0, 8'h3C, 8'h00, 8'h00, 1'b0, 3'd3, 8'hC3, 2, "ld_3c_c3");
      op(1'b0, 1'b1, 8'h10, 8'h01, 8'h02, 1'b0, 3'd2, 8'h02, 2, "pre_10");
      idle(2);

      // Reset in the middle of a store to 0x10 must abort it.
      @(negedge clk);
      memWrite_i = 1'b1;
      memAddr_i  = 8'h10;
      wdata_i    = 8'hFF;
      alu_i      = 8'h33;
      data_rd_i  = 3'd5;
      regWrite_i = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      drive_idle();
      #1;
      chk("midrst_wb", 32'(wb_data_o), 32'h0);
      chk("midrst_regwrite", 32'(regWrite_o), 32'h0);
      chk("midrst_rd", 32'(data_rd_o), 32'h0);
      chk("midrst_ovf", 32'(overflow_o), 32'h0);
      chk("midrst_stall", 32'(stall_o), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      op(1'b1, 1'b0, 8'h10, 8'h00, 8'h00, 1'b0, 3'd6, 8'h01, 2, "ld_10");
      idle(3);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
